// File: rtl/color_bbox_pkg.sv
// Shared widths, empty-accumulator constants and overlay colour for the colour bbox tracker.
package color_bbox_pkg;

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned CNT_W = 19;

    localparam logic [X_W-1:0]   X_EMPTY_MIN = '1;
    localparam logic [X_W-1:0]   X_EMPTY_MAX = '0;
    localparam logic [Y_W-1:0]   Y_EMPTY_MIN = '1;
    localparam logic [Y_W-1:0]   Y_EMPTY_MAX = '0;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [7:0] OVL_R = 8'd255;
    localparam logic [7:0] OVL_G = 8'd255;
    localparam logic [7:0] OVL_B = 8'd0;

    typedef struct packed {
        logic [X_W-1:0]   xmin;
        logic [X_W-1:0]   xmax;
        logic [Y_W-1:0]   ymin;
        logic [Y_W-1:0]   ymax;
        logic [CNT_W-1:0] count;
    } acc_t;

    localparam acc_t ACC_EMPTY = '{
        xmin:  X_EMPTY_MIN,
        xmax:  X_EMPTY_MAX,
        ymin:  Y_EMPTY_MIN,
        ymax:  Y_EMPTY_MAX,
        count: '0
    };

    // The highlight stage leaves non-selected pixels gray (r == g == b).
    function automatic logic is_coloured(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
        return !((r == g) && (g == b));
    endfunction

endpackage

// File: rtl/bbox_overlay.sv
// Perimeter compare and colour mux drawing the latched bounding box onto the video stream.
module bbox_overlay
    import color_bbox_pkg::*;
(
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           de,
    input  logic           box_valid,
    input  logic [X_W-1:0] xmin,
    input  logic [X_W-1:0] xmax,
    input  logic [Y_W-1:0] ymin,
    input  logic [Y_W-1:0] ymax,
    input  logic [7:0]     in_r,
    input  logic [7:0]     in_g,
    input  logic [7:0]     in_b,
    output logic [7:0]     out_r,
    output logic [7:0]     out_g,
    output logic [7:0]     out_b
);

    logic in_x_span, in_y_span, on_vert, on_horz, draw;

    always_comb begin
        in_x_span = (x >= xmin) && (x <= xmax);
        in_y_span = (y >= ymin) && (y <= ymax);
        on_vert   = ((x == xmin) || (x == xmax)) && in_y_span;
        on_horz   = ((y == ymin) || (y == ymax)) && in_x_span;
        draw      = de && box_valid && (on_vert || on_horz);
        out_r     = draw ? OVL_R : in_r;
        out_g     = draw ? OVL_G : in_g;
        out_b     = draw ? OVL_B : in_b;
    end

endmodule

// File: rtl/color_bbox_tracker.sv
// Per-frame bounding box and count of highlighted pixels, with registered video pass-through.
// Optional box drawing on the output video is enabled by defining COLOR_BBOX_OVERLAY_EN.
module color_bbox_tracker
    import color_bbox_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_r,
    input  logic [7:0]       in_g,
    input  logic [7:0]       in_b,
    input  logic             in_de,
    input  logic             in_vs,
    output logic [X_W-1:0]   bbox_xmin,
    output logic [X_W-1:0]   bbox_xmax,
    output logic [Y_W-1:0]   bbox_ymin,
    output logic [Y_W-1:0]   bbox_ymax,
    output logic [CNT_W-1:0] bbox_count,
    output logic             bbox_valid,
    output logic             frame_done,
    output logic [7:0]       out_r,
    output logic [7:0]       out_g,
    output logic [7:0]       out_b,
    output logic             out_de,
    output logic             out_vs
);

    localparam logic [X_W-1:0]   H_LIM   = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   V_LIM   = Y_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           de_q, de_d;
    logic           armed_q, armed_d;
    acc_t           acc_q, acc_d;
    acc_t           box_q, box_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic           pix_hit;
    logic [7:0]     pix_r, pix_g, pix_b;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        de_d    = in_vs ? 1'b0 : in_de;  // a pixel swallowed by vs must not end a line
        armed_d = armed_q;
        acc_d   = acc_q;
        box_d   = box_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        pix_hit = in_de && is_coloured(in_r, in_g, in_b) && (x_q < H_LIM) && (y_q < V_LIM);

        if (in_vs) begin
            if (armed_q) begin
                box_d   = acc_q;
                valid_d = (acc_q.count >= MIN_CNT);
                done_d  = 1'b1;
            end
            armed_d = 1'b1;
            acc_d   = ACC_EMPTY;
            x_d     = '0;
            y_d     = '0;
        end else if (in_de) begin
            if (x_q != H_LIM) x_d = x_q + 1'b1;
            if (pix_hit) begin
                if (x_q < acc_q.xmin) acc_d.xmin = x_q;
                if (x_q > acc_q.xmax) acc_d.xmax = x_q;
                if (y_q < acc_q.ymin) acc_d.ymin = y_q;
                if (y_q > acc_q.ymax) acc_d.ymax = y_q;
                if (acc_q.count != CNT_MAX) acc_d.count = acc_q.count + 1'b1;
            end
        end else if (de_q) begin
            x_d = '0;
            if (y_q != V_LIM) y_d = y_q + 1'b1;
        end
    end

`ifdef COLOR_BBOX_OVERLAY_EN
    bbox_overlay u_overlay (
        .x         (x_q),
        .y         (y_q),
        .de        (in_de),
        .box_valid (valid_q),
        .xmin      (box_q.xmin),
        .xmax      (box_q.xmax),
        .ymin      (box_q.ymin),
        .ymax      (box_q.ymax),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_r     (pix_r),
        .out_g     (pix_g),
        .out_b     (pix_b)
    );
`else
    assign pix_r = in_r;
    assign pix_g = in_g;
    assign pix_b = in_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            armed_q <= 1'b0;
            acc_q   <= ACC_EMPTY;
            box_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            out_r   <= '0;
            out_g   <= '0;
            out_b   <= '0;
            out_de  <= 1'b0;
            out_vs  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            de_q    <= de_d;
            armed_q <= armed_d;
            acc_q   <= acc_d;
            box_q   <= box_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            out_r   <= pix_r;
            out_g   <= pix_g;
            out_b   <= pix_b;
            out_de  <= in_de;
            out_vs  <= in_vs;
        end
    end

    assign bbox_xmin  = box_q.xmin;
    assign bbox_xmax  = box_q.xmax;
    assign bbox_ymin  = box_q.ymin;
    assign bbox_ymax  = box_q.ymax;
    assign bbox_count = box_q.count;
    assign bbox_valid = valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_color_bbox_tracker.sv
// Directed bench for color_bbox_tracker on a 4x4 frame with MIN_COUNT=2.
module tb_color_bbox_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_de, in_vs;
    logic [9:0]  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic [18:0] bbox_count;
    logic        bbox_valid, frame_done;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_de, out_vs;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    color_bbox_tracker #(
        .H_ACTIVE  (4),
        .V_ACTIVE  (4),
        .MIN_COUNT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .in_de      (in_de),
        .in_vs      (in_vs),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .bbox_count (bbox_count),
        .bbox_valid (bbox_valid),
        .frame_done (frame_done),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_de     (out_de),
        .out_vs     (out_vs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic vs, input logic de, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
        in_vs = vs;
        in_de = de;
        in_r  = r;
        in_g  = g;
        in_b  = b;
        @(posedge clk);
        #1;
    endtask

    // mask bit i set: pixel i red (200,10,10), else gray (90,90,90); then one blank cycle
    task automatic send_line(input int len, input logic [7:0] mask);
        for (int i = 0; i < len; i++) begin
            if (mask[i]) step(1'b0, 1'b1, 8'd200, 8'd10, 8'd10);
            else step(1'b0, 1'b1, 8'd90, 8'd90, 8'd90);
        end
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic check_box(input string tag, input int xmin, input int xmax, input int ymin,
                             input int ymax, input int cnt, input logic valid);
        check({tag, "_xmin"}, 32'(bbox_xmin), xmin);
        check({tag, "_xmax"}, 32'(bbox_xmax), xmax);
        check({tag, "_ymin"}, 32'(bbox_ymin), ymin);
        check({tag, "_ymax"}, 32'(bbox_ymax), ymax);
        check({tag, "_count"}, 32'(bbox_count), cnt);
        check({tag, "_valid"}, 32'(bbox_valid), 32'(valid));
    endtask

    initial begin
        logic [7:0] exp_px;
        logic       on_box;

        rst_n = 1'b0;
        in_vs = 1'b0;
        in_de = 1'b0;
        in_r  = 8'd0;
        in_g  = 8'd0;
        in_b  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_box("reset", 0, 0, 0, 0, 0, 1'b0);
        check("reset_done", 32'(frame_done), 0);
        check("reset_out_r", 32'(out_r), 0);
        check("reset_out_de", 32'(out_de), 0);
        rst_n = 1'b1;

        // first vs only arms
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check("first_vs_done", 32'(frame_done), 0);
        check("first_vs_out_vs", 32'(out_vs), 1);
        check_box("first_vs", 0, 0, 0, 0, 0, 1'b0);

        // all-gray frame
        for (int y = 0; y < 4; y++) send_line(4, 8'h00);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check("gray_done", 32'(frame_done), 1);
        check_box("gray", 1023, 0, 1023, 0, 0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("gray_done_pulse", 32'(frame_done), 0);

        // red at (1,1) and (2,3), plus a pass-through check on the red pixel
        send_line(4, 8'h00);
        step(1'b0, 1'b1, 8'd90, 8'd90, 8'd90);
        step(1'b0, 1'b1, 8'd200, 8'd10, 8'd10);
        check("pass_r", 32'(out_r), 200);
        check("pass_g", 32'(out_g), 10);
        check("pass_b", 32'(out_b), 10);
        check("pass_de", 32'(out_de), 1);
        step(1'b0, 1'b1, 8'd90, 8'd90, 8'd90);
        step(1'b0, 1'b1, 8'd90, 8'd90, 8'd90);
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check("pass_de_low", 32'(out_de), 0);
        send_line(4, 8'h00);
        send_line(4, 8'h04);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check("red_done", 32'(frame_done), 1);
        check_box("red", 1, 2, 1, 3, 2, 1'b1);
        repeat (3) step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        check_box("red_hold", 1, 2, 1, 3, 2, 1'b1);

        // overlong line: x=5 lies beyond H_ACTIVE
        send_line(6, 8'h22);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check_box("wide", 1, 1, 0, 0, 1, 1'b0);

        // frame closed by vs arriving together with a coloured pixel
        send_line(4, 8'h05);
        step(1'b1, 1'b1, 8'd200, 8'd10, 8'd10);
        check("vsde_done", 32'(frame_done), 1);
        check_box("vsde_prev", 0, 2, 0, 0, 2, 1'b1);
        step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        send_line(4, 8'h01);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check_box("vsde_next", 0, 0, 0, 0, 1, 1'b0);

        // asynchronous reset in the middle of a frame
        send_line(4, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check_box("midrst", 0, 0, 0, 0, 0, 1'b0);
        check("midrst_done", 32'(frame_done), 0);
        check("midrst_out_de", 32'(out_de), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check("midrst_vs_done", 32'(frame_done), 0);
        send_line(4, 8'h01);
        send_line(4, 8'h00);
        send_line(4, 8'h08);
        send_line(4, 8'h00);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check("after_rst_done", 32'(frame_done), 1);
        check_box("after_rst", 0, 3, 0, 2, 2, 1'b1);

        // box (1,2,1,2), then a frame of gray 50 watched on the output
        send_line(4, 8'h00);
        send_line(4, 8'h02);
        send_line(4, 8'h04);
        send_line(4, 8'h00);
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check_box("ovl_box", 1, 2, 1, 2, 2, 1'b1);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                step(1'b0, 1'b1, 8'd50, 8'd50, 8'd50);
                on_box = ((x == 1 || x == 2) && y >= 1 && y <= 2);
`ifdef COLOR_BBOX_OVERLAY_EN
                exp_px = on_box ? 8'd255 : 8'd50;
                check("ovl_r", 32'(out_r), 32'(exp_px));
                exp_px = on_box ? 8'd255 : 8'd50;
                check("ovl_g", 32'(out_g), 32'(exp_px));
                exp_px = on_box ? 8'd0 : 8'd50;
                check("ovl_b", 32'(out_b), 32'(exp_px));
`else
                exp_px = 8'd50;
                check("thru_r", 32'(out_r), 32'(exp_px));
                check("thru_b", 32'(out_b), 32'(exp_px));
`endif
            end
            step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        end
        step(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        check_box("gray50", 1023, 0, 1023, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
